exc_commit_ctrl: RTL and testbench

- Commit-side exception/flush controller that sits directly upstream of the CP0 register file.
- Takes the oldest committing instruction plus pending-interrupt lines from CP0, and resolves exception priority, EPC, BadVAddr and exccode.
- Drains outstanding memory operations, then issues a single-cycle `exception_t` / `flush_src_t` pulse that CP0 consumes to update Status/Cause/EPC/EntryHi and select the redirect target.
- Also sequences ERET and privileged-instruction refetch flushes.

---
 rtl/exc_commit_ctrl_pkg.sv | 62 ++++++
 rtl/exc_commit_ctrl_prio.sv | 99 +++++++++
 rtl/exc_commit_ctrl.sv | 129 ++++++++++++
 tb/tb_exc_commit_ctrl.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_commit_ctrl_pkg.sv
// Shared types for the commit-side exception controller: flag positions,
// exccodes, the CP0-facing exception record and flush-source strobes.
package exc_commit_ctrl_pkg;

    localparam int EXC_VEC_W = 12;
    typedef logic [EXC_VEC_W-1:0] exc_vec_t;

    // Flag positions are ordered from highest to lowest priority.
    localparam int EXC_F_ADEL = 0;
    localparam int EXC_F_TLBL = 1;
    localparam int EXC_RI     = 2;
    localparam int EXC_CPU    = 3;
    localparam int EXC_SYS    = 4;
    localparam int EXC_BP     = 5;
    localparam int EXC_OV     = 6;
    localparam int EXC_D_ADEL = 7;
    localparam int EXC_D_ADES = 8;
    localparam int EXC_D_TLBL = 9;
    localparam int EXC_D_TLBS = 10;
    localparam int EXC_MOD    = 11;

    localparam logic [4:0] EXCCODE_INT  = 5'd0;
    localparam logic [4:0] EXCCODE_MOD  = 5'd1;
    localparam logic [4:0] EXCCODE_TLBL = 5'd2;
    localparam logic [4:0] EXCCODE_TLBS = 5'd3;
    localparam logic [4:0] EXCCODE_ADEL = 5'd4;
    localparam logic [4:0] EXCCODE_ADES = 5'd5;
    localparam logic [4:0] EXCCODE_SYS  = 5'd8;
    localparam logic [4:0] EXCCODE_BP   = 5'd9;
    localparam logic [4:0] EXCCODE_RI   = 5'd10;
    localparam logic [4:0] EXCCODE_CPU  = 5'd11;
    localparam logic [4:0] EXCCODE_OV   = 5'd12;

    typedef struct packed {
        logic        ex;
        logic [4:0]  exccode;
        logic [31:0] epc;
        logic [31:0] badvaddr;
        logic        bd;
        logic        tlb_refill;
    } exception_t;

    typedef struct packed {
        logic eret;
        logic exception;
        logic privileged_inst;
    } flush_src_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_FLUSH
    } exc_state_e;

    typedef enum logic [1:0] {
        KIND_NONE,
        KIND_EXC,
        KIND_ERET,
        KIND_PRIV
    } evt_kind_e;

endpackage

// File: rtl/exc_commit_ctrl_prio.sv
// Combinational priority resolver: turns the committing instruction's fields
// into the record CP0 will consume (kind, exccode, EPC, BadVAddr, refill).
module exc_prio_enc
    import exc_commit_ctrl_pkg::*;
(
    input  logic        i_commit_valid,
    input  logic [31:0] i_commit_pc,
    input  logic        i_commit_bd,
    input  exc_vec_t    i_commit_exc,
    input  logic        i_refill_f,
    input  logic        i_refill_d,
    input  logic [31:0] i_data_vaddr,
    input  logic        i_eret,
    input  logic        i_priv,
    input  logic [5:0]  i_cp0_hw,
    input  logic [1:0]  i_cp0_sw,
    output evt_kind_e   o_kind,
    output exception_t  o_rec
);

    logic        w_int;
    logic        w_exc_hit;
    logic [4:0]  w_code;
    logic [31:0] w_badvaddr;
    logic        w_refill;

    assign w_int = (|i_cp0_hw) | (|i_cp0_sw);

    always_comb begin
        w_exc_hit  = 1'b1;
        w_code     = EXCCODE_INT;
        w_badvaddr = '0;
        w_refill   = 1'b0;
        if (w_int) begin
            w_code = EXCCODE_INT;
        end else if (i_commit_exc[EXC_F_ADEL]) begin
            w_code     = EXCCODE_ADEL;
            w_badvaddr = i_commit_pc;
        end else if (i_commit_exc[EXC_F_TLBL]) begin
            w_code     = EXCCODE_TLBL;
            w_badvaddr = i_commit_pc;
            w_refill   = i_refill_f;
        end else if (i_commit_exc[EXC_RI]) begin
            w_code = EXCCODE_RI;
        end else if (i_commit_exc[EXC_CPU]) begin
            w_code = EXCCODE_CPU;
        end else if (i_commit_exc[EXC_SYS]) begin
            w_code = EXCCODE_SYS;
        end else if (i_commit_exc[EXC_BP]) begin
            w_code = EXCCODE_BP;
        end else if (i_commit_exc[EXC_OV]) begin
            w_code = EXCCODE_OV;
        end else if (i_commit_exc[EXC_D_ADEL]) begin
            w_code     = EXCCODE_ADEL;
            w_badvaddr = i_data_vaddr;
        end else if (i_commit_exc[EXC_D_ADES]) begin
            w_code     = EXCCODE_ADES;
            w_badvaddr = i_data_vaddr;
        end else if (i_commit_exc[EXC_D_TLBL]) begin
            w_code     = EXCCODE_TLBL;
            w_badvaddr = i_data_vaddr;
            w_refill   = i_refill_d;
        end else if (i_commit_exc[EXC_D_TLBS]) begin
            w_code     = EXCCODE_TLBS;
            w_badvaddr = i_data_vaddr;
            w_refill   = i_refill_d;
        end else if (i_commit_exc[EXC_MOD]) begin
            w_code     = EXCCODE_MOD;
            w_badvaddr = i_data_vaddr;
        end else begin
            w_exc_hit = 1'b0;
        end
    end

    always_comb begin
        o_kind = KIND_NONE;
        o_rec  = '0;
        if (i_commit_valid) begin
            o_rec.bd  = i_commit_bd;
            o_rec.epc = i_commit_bd ? (i_commit_pc - 32'd4) : i_commit_pc;
            if (w_exc_hit) begin
                o_kind           = KIND_EXC;
                o_rec.ex         = 1'b1;
                o_rec.exccode    = w_code;
                o_rec.badvaddr   = w_badvaddr;
                o_rec.tlb_refill = w_refill;
            end else if (i_eret) begin
                o_kind = KIND_ERET;
            end else if (i_priv) begin
                // Refetch restarts at the instruction after the privileged op.
                o_kind    = KIND_PRIV;
                o_rec.epc = i_commit_pc + 32'd4;
            end else begin
                o_rec = '0;
            end
        end
    end

endmodule

// File: rtl/exc_commit_ctrl.sv
// Commit-side exception/flush sequencer: captures the resolved record, waits
// for the LSU to drain (bounded), then emits a one-cycle pulse to CP0.
module exc_commit_ctrl
    import exc_commit_ctrl_pkg::*;
#(
    parameter int DRAIN_MAX = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_commit_valid,
    output logic        o_commit_ready,
    input  logic [31:0] i_commit_pc,
    input  logic        i_commit_bd,
    input  exc_vec_t    i_commit_exc,
    input  logic        i_commit_refill_f,
    input  logic        i_commit_refill_d,
    input  logic [31:0] i_commit_data_vaddr,
    input  logic        i_commit_eret,
    input  logic        i_commit_priv,
    input  logic [5:0]  i_cp0_hw,
    input  logic [1:0]  i_cp0_sw,
    input  logic        i_mem_busy,
    output exception_t  o_exception,
    output flush_src_t  o_flush_src,
    output logic        o_flush_busy,
    output logic        o_drain_timeout
);

    localparam int              CNT_W   = $clog2(DRAIN_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DRAIN_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    exc_state_e       r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    exception_t       r_rec, w_rec_next;
    evt_kind_e        r_kind, w_kind_next;
    logic             r_timeout, w_timeout_next;

    evt_kind_e        w_enc_kind;
    exception_t       w_enc_rec;

    exc_prio_enc u_prio (
        .i_commit_valid (i_commit_valid),
        .i_commit_pc    (i_commit_pc),
        .i_commit_bd    (i_commit_bd),
        .i_commit_exc   (i_commit_exc),
        .i_refill_f     (i_commit_refill_f),
        .i_refill_d     (i_commit_refill_d),
        .i_data_vaddr   (i_commit_data_vaddr),
        .i_eret         (i_commit_eret),
        .i_priv         (i_commit_priv),
        .i_cp0_hw       (i_cp0_hw),
        .i_cp0_sw       (i_cp0_sw),
        .o_kind         (w_enc_kind),
        .o_rec          (w_enc_rec)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_rec     <= '0;
            r_kind    <= KIND_NONE;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_rec     <= w_rec_next;
            r_kind    <= w_kind_next;
            r_timeout <= w_timeout_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_rec_next     = r_rec;
        w_kind_next    = r_kind;
        w_timeout_next = r_timeout;
        o_commit_ready = 1'b0;
        o_flush_busy   = 1'b1;
        o_exception    = '0;
        o_flush_src    = '0;
        case (r_state)
            ST_IDLE: begin
                o_commit_ready = 1'b1;
                o_flush_busy   = 1'b0;
                w_cnt_next     = '0;
                if (w_enc_kind != KIND_NONE) begin
                    w_rec_next  = w_enc_rec;
                    w_kind_next = w_enc_kind;
                    // The counter holds the number of the DRAIN cycle in progress.
                    if (i_mem_busy) begin
                        w_state_next = ST_DRAIN;
                        w_cnt_next   = CNT_ONE;
                    end else begin
                        w_state_next = ST_FLUSH;
                    end
                end
            end
            ST_DRAIN: begin
                if (!i_mem_busy) begin
                    w_state_next = ST_FLUSH;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_next   = ST_FLUSH;
                    w_timeout_next = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + CNT_ONE;
                end
            end
            ST_FLUSH: begin
                o_exception                 = r_rec;
                o_flush_src.exception       = (r_kind == KIND_EXC);
                o_flush_src.eret            = (r_kind == KIND_ERET);
                o_flush_src.privileged_inst = (r_kind == KIND_PRIV);
                w_state_next                = ST_IDLE;
                w_cnt_next                  = '0;
                w_rec_next                  = '0;
                w_kind_next                 = KIND_NONE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign o_drain_timeout = r_timeout;

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Self-checking bench for exc_commit_ctrl: directed scenarios plus random
// commits checked against a priority-list reference model.
module tb_exc_commit_ctrl;
    import exc_commit_ctrl_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        i_commit_valid;
    logic        o_commit_ready;
    logic [31:0] i_commit_pc;
    logic        i_commit_bd;
    exc_vec_t    i_commit_exc;
    logic        i_commit_refill_f;
    logic        i_commit_refill_d;
    logic [31:0] i_commit_data_vaddr;
    logic        i_commit_eret;
    logic        i_commit_priv;
    logic [5:0]  i_cp0_hw;
    logic [1:0]  i_cp0_sw;
    logic        i_mem_busy;
    exception_t  o_exception;
    flush_src_t  o_flush_src;
    logic        o_flush_busy;
    logic        o_drain_timeout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic        bd;
        exc_vec_t    exc;
        logic        rf;
        logic        rd;
        logic [31:0] vaddr;
        logic        eret;
        logic        priv;
        logic [5:0]  hw;
        logic [1:0]  sw;
    } stim_t;

    // exccode per flag bit; bit index doubles as priority rank (0 = highest).
    logic [4:0] code_tab [12] = '{5'd4, 5'd2, 5'd10, 5'd11, 5'd8, 5'd9,
                                  5'd12, 5'd4, 5'd5, 5'd2, 5'd3, 5'd1};

    exc_commit_ctrl #(.DRAIN_MAX(255)) dut (
        .i_clk               (clk),
        .i_reset             (rst_n),
        .i_commit_valid      (i_commit_valid),
        .o_commit_ready      (o_commit_ready),
        .i_commit_pc         (i_commit_pc),
        .i_commit_bd         (i_commit_bd),
        .i_commit_exc        (i_commit_exc),
        .i_commit_refill_f   (i_commit_refill_f),
        .i_commit_refill_d   (i_commit_refill_d),
        .i_commit_data_vaddr (i_commit_data_vaddr),
        .i_commit_eret       (i_commit_eret),
        .i_commit_priv       (i_commit_priv),
        .i_cp0_hw            (i_cp0_hw),
        .i_cp0_sw            (i_cp0_sw),
        .i_mem_busy          (i_mem_busy),
        .o_exception         (o_exception),
        .o_flush_src         (o_flush_src),
        .o_flush_busy        (o_flush_busy),
        .o_drain_timeout     (o_drain_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic stim_t mk(input logic [31:0] pc, input logic bd, input exc_vec_t exc);
        stim_t s;
        s.valid = 1'b1; s.pc = pc; s.bd = bd; s.exc = exc;
        s.rf = 1'b0; s.rd = 1'b0; s.vaddr = '0; s.eret = 1'b0; s.priv = 1'b0;
        s.hw = '0; s.sw = '0;
        return s;
    endfunction

    // Reference: interrupt first, then first set flag in rank order, then ERET, then priv.
    function automatic void model(input stim_t s, output exception_t e, output flush_src_t f);
        int hit;
        e = '0;
        f = '0;
        hit = -1;
        if (!s.valid) return;
        if (s.hw != 6'd0 || s.sw != 2'd0) hit = 99;
        else for (int b = 0; b < 12; b++) if (hit < 0 && s.exc[b]) hit = b;
        if (hit >= 0) begin
            f.exception = 1'b1;
            e.ex  = 1'b1;
            e.bd  = s.bd;
            e.epc = s.bd ? s.pc - 32'd4 : s.pc;
            if (hit != 99) begin
                e.exccode = code_tab[hit];
                if (hit <= 1) e.badvaddr = s.pc;
                else if (hit >= 7) e.badvaddr = s.vaddr;
                if (hit == 1) e.tlb_refill = s.rf;
                else if (hit == 9 || hit == 10) e.tlb_refill = s.rd;
            end
        end else if (s.eret) begin
            f.eret = 1'b1;
            e.epc  = s.bd ? s.pc - 32'd4 : s.pc;
        end else if (s.priv) begin
            f.privileged_inst = 1'b1;
            e.epc = s.pc + 32'd4;
        end
    endfunction

    task automatic drive(input stim_t s);
        i_commit_valid      = s.valid;
        i_commit_pc         = s.pc;
        i_commit_bd         = s.bd;
        i_commit_exc        = s.exc;
        i_commit_refill_f   = s.rf;
        i_commit_refill_d   = s.rd;
        i_commit_data_vaddr = s.vaddr;
        i_commit_eret       = s.eret;
        i_commit_priv       = s.priv;
        i_cp0_hw            = s.hw;
        i_cp0_sw            = s.sw;
    endtask

    task automatic clear_commit();
        i_commit_valid = 1'b0; i_commit_pc = '0; i_commit_bd = 1'b0; i_commit_exc = '0;
        i_commit_refill_f = 1'b0; i_commit_refill_d = 1'b0; i_commit_data_vaddr = '0;
        i_commit_eret = 1'b0; i_commit_priv = 1'b0; i_cp0_hw = '0; i_cp0_sw = '0;
    endtask

    // Presents one commit, keeps mem_busy high for busy_len DRAIN cycles, and
    // reports what the DUT emitted. No comparisons here.
    task automatic run_event(input stim_t s, input bit drain, input int busy_len,
                             output exception_t got_e, output flush_src_t got_f,
                             output int n_drain, output bit pulsed,
                             output bit ready_low, output bit after_zero);
        got_e = '0; got_f = '0; n_drain = 0; pulsed = 1'b0; ready_low = 1'b1; after_zero = 1'b0;
        drive(s);
        i_mem_busy = drain;
        @(negedge clk);
        clear_commit();
        for (int c = 0; c < 400 && !pulsed; c++) begin
            i_mem_busy = drain && (c < busy_len);
            #1;
            if (o_flush_src != '0) begin
                pulsed = 1'b1; got_e = o_exception; got_f = o_flush_src;
            end else if (o_flush_busy) begin
                n_drain++;
            end
            if (o_flush_busy && o_commit_ready) ready_low = 1'b0;
            @(negedge clk);
        end
        i_mem_busy = 1'b0;
        #1;
        after_zero = (o_exception == '0) && (o_flush_src == '0) && !o_flush_busy && o_commit_ready;
    endtask

    task automatic test_reset();
        checks++;
        if (o_exception !== '0 || o_flush_src !== '0 || o_flush_busy !== 1'b0 ||
            o_drain_timeout !== 1'b0 || o_commit_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs got exc=%h fs=%b busy=%b to=%b rdy=%b required all 0, rdy=1",
                     o_exception, o_flush_src, o_flush_busy, o_drain_timeout, o_commit_ready);
        end
    endtask

    task automatic test_syscall();
        stim_t s; exception_t ge, ee; flush_src_t gf, ef; int nd; bit p, rl, az;
        s = mk(32'h8000_1000, 1'b0, '0);
        s.exc[EXC_SYS] = 1'b1;
        model(s, ee, ef);
        run_event(s, 1'b0, 0, ge, gf, nd, p, rl, az);
        $display("txn syscall pc=%h exccode=%0d epc=%h fs=%b", s.pc, ge.exccode, ge.epc, gf);
        checks++;
        if (ge !== ee) begin errors++; $display("FAIL syscall_record got %h required %h", ge, ee); end
        checks++;
        if (ge.exccode !== 5'd8 || ge.epc !== 32'h8000_1000 || gf !== 3'b010) begin
            errors++; $display("FAIL syscall_fields got code=%0d epc=%h fs=%b required 8 80001000 010",
                               ge.exccode, ge.epc, gf);
        end
        checks++;
        if (nd !== 0) begin errors++; $display("FAIL syscall_latency got drain=%0d required 0", nd); end
        checks++;
        if (az !== 1'b1) begin errors++; $display("FAIL syscall_single_pulse got after_zero=%b required 1", az); end

        s = mk(32'h0000_0000, 1'b1, '0);
        s.exc[EXC_SYS] = 1'b1;
        run_event(s, 1'b0, 0, ge, gf, nd, p, rl, az);
        $display("txn wrap pc=%h bd=1 epc=%h", s.pc, ge.epc);
        checks++;
        if (ge.epc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL epc_wrap got %h required fffffffc", ge.epc); end
    endtask

    task automatic test_drain_adel();
        stim_t s; exception_t ge, ee; flush_src_t gf, ef; int nd; bit p, rl, az;
        s = mk(32'h8000_2004, 1'b1, '0);
        s.exc[EXC_D_ADEL] = 1'b1;
        s.vaddr = 32'h0000_0003;
        model(s, ee, ef);
        run_event(s, 1'b1, 4, ge, gf, nd, p, rl, az);
        $display("txn adel_drain drain=%0d exccode=%0d epc=%h bad=%h", nd, ge.exccode, ge.epc, ge.badvaddr);
        checks++;
        if (nd !== 5) begin errors++; $display("FAIL adel_drain_cycles got %0d required 5", nd); end
        checks++;
        if (ge !== ee || gf !== ef) begin errors++; $display("FAIL adel_record got %h/%b required %h/%b", ge, gf, ee, ef); end
        checks++;
        if (ge.exccode !== 5'd4 || ge.epc !== 32'h8000_2000 || ge.bd !== 1'b1 || ge.badvaddr !== 32'h3) begin
            errors++; $display("FAIL adel_fields got %h", ge);
        end
        checks++;
        if (rl !== 1'b1) begin errors++; $display("FAIL adel_ready_low got ready seen high while busy"); end
    endtask

    task automatic test_int_priority();
        stim_t s; exception_t ge, ee; flush_src_t gf, ef; int nd; bit p, rl, az;
        s = mk(32'h8000_0200, 1'b0, '0);
        s.exc[EXC_F_TLBL] = 1'b1;
        s.exc[EXC_RI] = 1'b1;
        s.rf = 1'b1;
        s.hw = 6'b000100;
        model(s, ee, ef);
        run_event(s, 1'b0, 0, ge, gf, nd, p, rl, az);
        $display("txn int_prio exccode=%0d bad=%h refill=%b", ge.exccode, ge.badvaddr, ge.tlb_refill);
        checks++;
        if (ge !== ee || ge.exccode !== 5'd0 || ge.badvaddr !== 32'h0 || ge.tlb_refill !== 1'b0) begin
            errors++; $display("FAIL int_priority got %h required %h", ge, ee);
        end
    endtask

    task automatic test_tlbs_refill();
        stim_t s; exception_t ge, ee; flush_src_t gf, ef; int nd; bit p, rl, az;
        s = mk(32'h8000_0300, 1'b0, '0);
        s.exc[EXC_D_TLBS] = 1'b1;
        s.rd = 1'b1;
        s.vaddr = 32'h0040_1234;
        model(s, ee, ef);
        run_event(s, 1'b0, 0, ge, gf, nd, p, rl, az);
        $display("txn tlbs exccode=%0d bad=%h refill=%b", ge.exccode, ge.badvaddr, ge.tlb_refill);
        checks++;
        if (ge !== ee || ge.exccode !== 5'd3 || ge.tlb_refill !== 1'b1 || ge.badvaddr !== 32'h0040_1234) begin
            errors++; $display("FAIL tlbs_refill got %h required %h", ge, ee);
        end
    endtask

    task automatic test_eret_priv();
        stim_t s; exception_t ge; flush_src_t gf; int nd; bit p, rl, az;
        s = mk(32'h8000_0400, 1'b0, '0);
        s.eret = 1'b1;
        run_event(s, 1'b0, 0, ge, gf, nd, p, rl, az);
        $display("txn eret fs=%b ex=%b", gf, ge.ex);
        checks++;
        if (gf !== 3'b100 || ge.ex !== 1'b0) begin errors++; $display("FAIL eret_flush got fs=%b ex=%b required 100 0", gf, ge.ex); end
        s = mk(32'h8000_3000, 1'b0, '0);
        s.priv = 1'b1;
        run_event(s, 1'b0, 0, ge, gf, nd, p, rl, az);
        $display("txn priv fs=%b ex=%b epc=%h", gf, ge.ex, ge.epc);
        checks++;
        if (gf !== 3'b001 || ge.ex !== 1'b0 || ge.epc !== 32'h8000_3004) begin
            errors++; $display("FAIL priv_flush got fs=%b ex=%b epc=%h required 001 0 80003004", gf, ge.ex, ge.epc);
        end
    endtask

    task automatic test_no_event();
        stim_t s; bit saw;
        saw = 1'b0;
        s = mk(32'h8000_0500, 1'b0, '0);
        drive(s);
        @(negedge clk);
        clear_commit();
        i_cp0_hw = 6'h3F;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (o_flush_busy || o_flush_src != '0 || o_exception != '0) saw = 1'b1;
            @(negedge clk);
        end
        clear_commit();
        $display("txn no_event saw_activity=%b", saw);
        checks++;
        if (saw !== 1'b0) begin errors++; $display("FAIL no_event got activity=1 required 0"); end
    endtask

    task automatic test_random();
        stim_t s; exception_t ge, ee; flush_src_t gf, ef; int nd, L, exp_nd; bit p, rl, az, dr;
        for (int t = 0; t < 40; t++) begin
            s = mk($urandom, 1'($urandom_range(0, 1)), exc_vec_t'($urandom & $urandom & $urandom));
            s.rf = 1'($urandom_range(0, 1));
            s.rd = 1'($urandom_range(0, 1));
            s.vaddr = $urandom;
            s.eret = ($urandom_range(0, 3) == 0);
            s.priv = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) s.hw = 6'($urandom);
            if ($urandom_range(0, 7) == 0) s.sw = 2'($urandom);
            model(s, ee, ef);
            if (ef == '0) begin s.priv = 1'b1; model(s, ee, ef); end
            dr = 1'($urandom_range(0, 1));
            L = $urandom_range(0, 5);
            exp_nd = dr ? L + 1 : 0;
            run_event(s, dr, L, ge, gf, nd, p, rl, az);
            $display("txn rnd%0d pc=%h exc=%h fs=%b code=%0d drain=%0d", t, s.pc, s.exc, gf, ge.exccode, nd);
            checks++;
            if (gf !== ef || p !== 1'b1) begin errors++; $display("FAIL rnd%0d_flush_src got %b required %b", t, gf, ef); end
            checks++;
            if (ef.exception ? (ge !== ee) : (ge.ex !== 1'b0 || ge.epc !== ee.epc)) begin
                errors++; $display("FAIL rnd%0d_record got %h required %h", t, ge, ee);
            end
            checks++;
            if (nd !== exp_nd || az !== 1'b1 || rl !== 1'b1) begin
                errors++; $display("FAIL rnd%0d_timing got drain=%0d az=%b rl=%b required %0d 1 1", t, nd, az, rl, exp_nd);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t a, b; exception_t ea, eb; flush_src_t fa, fb;
        int pc_at [2]; exception_t pe [2]; flush_src_t pf [2]; int np; bit held_ok, accept;
        a = mk(32'h8000_4000, 1'b0, '0);
        a.exc[EXC_OV] = 1'b1;
        b = mk(32'h8000_4100, 1'b0, '0);
        b.priv = 1'b1;
        model(a, ea, fa);
        model(b, eb, fb);
        np = 0; held_ok = 1'b1; accept = 1'b0;
        pc_at[0] = -1; pc_at[1] = -1; pe[0] = '0; pe[1] = '0; pf[0] = '0; pf[1] = '0;
        drive(a);
        i_mem_busy = 1'b1;
        @(negedge clk);
        drive(b);
        for (int c = 0; c < 40 && np < 2; c++) begin
            i_mem_busy = (c < 2);
            #1;
            if (o_flush_src != '0) begin pc_at[np] = c; pe[np] = o_exception; pf[np] = o_flush_src; np++; end
            if (o_flush_busy && o_commit_ready) held_ok = 1'b0;
            accept = i_commit_valid && o_commit_ready;
            @(negedge clk);
            if (accept) clear_commit();
        end
        clear_commit();
        i_mem_busy = 1'b0;
        $display("txn b2b pulses=%0d at %0d,%0d fs=%b,%b", np, pc_at[0], pc_at[1], pf[0], pf[1]);
        checks++;
        if (pc_at[0] !== 3 || pc_at[1] !== 5) begin
            errors++; $display("FAIL b2b_timing got %0d,%0d required 3,5", pc_at[0], pc_at[1]);
        end
        checks++;
        if (pe[0] !== ea || pf[0] !== fa || pf[1] !== fb || pe[1].epc !== eb.epc) begin
            errors++; $display("FAIL b2b_records got %h/%b %h/%b", pe[0], pf[0], pe[1], pf[1]);
        end
        checks++;
        if (held_ok !== 1'b1) begin errors++; $display("FAIL b2b_ready_held got ready high while busy"); end
    endtask

    task automatic test_drain_limits();
        stim_t s; exception_t ge; flush_src_t gf; int nd; bit p, rl, az;
        s = mk(32'h8000_6000, 1'b0, '0);
        s.exc[EXC_MOD] = 1'b1;
        run_event(s, 1'b1, 254, ge, gf, nd, p, rl, az);
        $display("txn drain254 drain=%0d timeout=%b", nd, o_drain_timeout);
        checks++;
        if (nd !== 255 || o_drain_timeout !== 1'b0 || p !== 1'b1) begin
            errors++; $display("FAIL drain_edge got drain=%0d to=%b required 255 0", nd, o_drain_timeout);
        end
        run_event(s, 1'b1, 300, ge, gf, nd, p, rl, az);
        $display("txn drain_stuck drain=%0d timeout=%b", nd, o_drain_timeout);
        checks++;
        if (nd !== 255 || o_drain_timeout !== 1'b1 || gf !== 3'b010) begin
            errors++; $display("FAIL drain_timeout got drain=%0d to=%b fs=%b required 255 1 010", nd, o_drain_timeout, gf);
        end
        run_event(s, 1'b0, 0, ge, gf, nd, p, rl, az);
        checks++;
        if (o_drain_timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky got %b required 1", o_drain_timeout); end
    endtask

    task automatic test_reset_mid_drain();
        stim_t s; bit saw;
        saw = 1'b0;
        s = mk(32'h8000_7000, 1'b0, '0);
        s.exc[EXC_D_TLBS] = 1'b1;
        drive(s);
        i_mem_busy = 1'b1;
        @(negedge clk);
        clear_commit();
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (o_flush_busy !== 1'b1) begin errors++; $display("FAIL mid_drain_busy got %b required 1", o_flush_busy); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (o_exception !== '0 || o_flush_src !== '0 || o_flush_busy !== 1'b0 || o_drain_timeout !== 1'b0) begin
            errors++; $display("FAIL reset_abort got exc=%h fs=%b busy=%b to=%b required all 0",
                               o_exception, o_flush_src, o_flush_busy, o_drain_timeout);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        i_mem_busy = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (o_flush_busy || o_flush_src != '0) saw = 1'b1;
            @(negedge clk);
        end
        $display("txn reset_mid_drain activity_after=%b", saw);
        checks++;
        if (saw !== 1'b0) begin errors++; $display("FAIL reset_no_pulse got activity=1 required 0"); end
    endtask

    initial begin
        clear_commit();
        i_mem_busy = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_syscall();
        test_drain_adel();
        test_int_priority();
        test_tlbs_refill();
        test_eret_priv();
        test_no_event();
        test_random();
        test_back_to_back();
        test_drain_limits();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
